// File: rtl/core_seq_if.sv
// Bundle between the sequencer and the rest of the core. The i_/o_ prefixes are
// from the sequencer's point of view. The master modport is the sequencer itself.
interface core_seq_if #(
    parameter int OP_W  = 5,
    parameter int CNT_W = 16
) ();
    logic             i_start;
    logic [OP_W-1:0]  i_op;
    logic             i_jump;
    logic             i_branch_en;
    logic             i_branch_taken;
    logic             i_mem_ready;

    logic             o_ir_load;
    logic             o_pc_en;
    logic             o_pc_load_target;
    logic             o_reg_wr_en;
    logic             o_mem_rd_en;
    logic             o_mem_wr_en;
    logic             o_busy;
    logic             o_done;
    logic             o_error;
    logic [2:0]       o_state;
    logic [CNT_W-1:0] o_cycle_count;
    logic [CNT_W-1:0] o_instr_count;

    modport master (
        input  i_start, i_op, i_jump, i_branch_en, i_branch_taken, i_mem_ready,
        output o_ir_load, o_pc_en, o_pc_load_target, o_reg_wr_en, o_mem_rd_en,
               o_mem_wr_en, o_busy, o_done, o_error, o_state, o_cycle_count,
               o_instr_count
    );

    modport slave (
        output i_start, i_op, i_jump, i_branch_en, i_branch_taken, i_mem_ready,
        input  o_ir_load, o_pc_en, o_pc_load_target, o_reg_wr_en, o_mem_rd_en,
               o_mem_wr_en, o_busy, o_done, o_error, o_state, o_cycle_count,
               o_instr_count
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB with Start/Done handshake,
// data-memory ready timeout and saturating cycle/instruction counters.
module core_sequencer #(
    parameter int OP_W        = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    core_seq_if.master io_seq
);
    // Opcode encodings shared with the decoder's definitions package.
    localparam logic [OP_W-1:0] oLOAD  = OP_W'(8);
    localparam logic [OP_W-1:0] oSTORE = OP_W'(9);
    localparam logic [OP_W-1:0] oHALT  = OP_W'(31);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [OP_W-1:0]  r_op_q;
    logic             r_jmp_q;
    logic             r_br_q;
    logic [7:0]       r_wait_cnt;
    logic             r_error;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_instr_cnt;

    logic w_ir_load, w_pc_en, w_pc_load_target, w_reg_wr_en;
    logic w_mem_rd_en, w_mem_wr_en, w_done;
    logic w_clr_wait, w_inc_wait, w_set_err, w_clr_cnt;
    logic w_busy, w_enter_fetch, w_is_mem;

    assign w_is_mem      = (r_op_q == oLOAD) || (r_op_q == oSTORE);
    assign w_busy        = (r_state != S_IDLE) && (r_state != S_HALTED);
    // The IDLE->FETCH launch preloads the count instead of incrementing it.
    assign w_enter_fetch = (w_next_state == S_FETCH) && (r_state != S_IDLE);

    always_comb begin
        w_next_state     = r_state;
        w_ir_load        = 1'b0;
        w_pc_en          = 1'b0;
        w_pc_load_target = 1'b0;
        w_reg_wr_en      = 1'b0;
        w_mem_rd_en      = 1'b0;
        w_mem_wr_en      = 1'b0;
        w_done           = 1'b0;
        w_clr_wait       = 1'b0;
        w_inc_wait       = 1'b0;
        w_set_err        = 1'b0;
        w_clr_cnt        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_seq.i_start) begin
                    w_clr_cnt    = 1'b1;
                    w_next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                w_ir_load    = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                w_next_state = (io_seq.i_op == oHALT) ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                if (w_is_mem) begin
                    w_clr_wait   = 1'b1;
                    w_next_state = S_MEM;
                end else if (r_jmp_q || r_br_q) begin
                    w_pc_en          = 1'b1;
                    w_pc_load_target = r_jmp_q || (r_br_q && io_seq.i_branch_taken);
                    w_next_state     = S_FETCH;
                end else begin
                    w_next_state = S_WB;
                end
            end
            S_MEM: begin
                w_mem_rd_en = (r_op_q == oLOAD);
                w_mem_wr_en = (r_op_q == oSTORE);
                if (io_seq.i_mem_ready) begin
                    w_next_state = S_WB;
                end else if (r_wait_cnt == 8'(MEM_TIMEOUT - 1)) begin
                    w_set_err    = 1'b1;
                    w_next_state = S_HALTED;
                end else begin
                    w_inc_wait = 1'b1;
                end
            end
            S_WB: begin
                w_pc_en      = 1'b1;
                w_reg_wr_en  = (r_op_q != oSTORE);
                w_next_state = S_FETCH;
            end
            S_HALTED: begin
                w_done = 1'b1;
                // A level-held Start must drop before another launch is possible.
                if (!io_seq.i_start) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_op_q      <= '0;
            r_jmp_q     <= 1'b0;
            r_br_q      <= 1'b0;
            r_wait_cnt  <= '0;
            r_error     <= 1'b0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_op_q  <= io_seq.i_op;
                r_jmp_q <= io_seq.i_jump;
                r_br_q  <= io_seq.i_branch_en;
            end
            if (w_clr_wait)      r_wait_cnt <= '0;
            else if (w_inc_wait) r_wait_cnt <= r_wait_cnt + 8'd1;
            if (w_clr_cnt)      r_error <= 1'b0;
            else if (w_set_err) r_error <= 1'b1;
            if (w_clr_cnt)                           r_cycle_cnt <= '0;
            else if (w_busy && (r_cycle_cnt != '1))  r_cycle_cnt <= r_cycle_cnt + 1'b1;
            if (w_clr_cnt)                                 r_instr_cnt <= CNT_W'(1);
            else if (w_enter_fetch && (r_instr_cnt != '1)) r_instr_cnt <= r_instr_cnt + 1'b1;
        end
    end

    assign io_seq.o_ir_load        = w_ir_load;
    assign io_seq.o_pc_en          = w_pc_en;
    assign io_seq.o_pc_load_target = w_pc_load_target;
    assign io_seq.o_reg_wr_en      = w_reg_wr_en;
    assign io_seq.o_mem_rd_en      = w_mem_rd_en;
    assign io_seq.o_mem_wr_en      = w_mem_wr_en;
    assign io_seq.o_busy           = w_busy;
    assign io_seq.o_done           = w_done;
    assign io_seq.o_error          = r_error;
    assign io_seq.o_state          = r_state;
    assign io_seq.o_cycle_count    = r_cycle_cnt;
    assign io_seq.o_instr_count    = r_instr_cnt;

    a_mem_onehot: assert property (@(posedge i_clk) !(w_mem_rd_en && w_mem_wr_en));
    a_pc_vs_ir:   assert property (@(posedge i_clk) !(w_pc_en && w_ir_load));
endmodule
